// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-memory write bus of imem_loader.
// master = stream source / memory observer, slave = the loader itself.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [14:0]       im_wdata;

    modport master (
        output in_data, in_valid,
        input  in_ready, im_we, im_addr, im_wdata
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, im_we, im_addr, im_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Framed byte-stream loader: packs {HI, LO} byte pairs into 15-bit words and writes
// them to instruction memory while holding the CPU. LOADER_CHECKSUM_EN adds a CHK byte.
module imem_loader #(
    parameter int ADDR_W      = 8,
    parameter int START_ADDR  = 0,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    imem_loader_if.slave        bus,
    output logic                cpu_hold,
    output logic                done,
    output logic                err,
    output logic [7:0]          words_loaded
);

    localparam logic [7:0]        SYNC     = 8'hA5;
    localparam logic [ADDR_W-1:0] START    = ADDR_W'(START_ADDR);
    localparam int                CAPACITY = (1 << ADDR_W) - START_ADDR;
    localparam int                TW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_HI,
        S_LO,
`ifdef LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERR
    } state_t;

    // State that follows the last data word (or LEN when N is zero).
`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_TAIL = S_CHK;
`else
    localparam state_t S_TAIL = S_DONE;
`endif

    state_t        state;
    logic [6:0]    opcode;
    logic [7:0]    remaining;
    logic [TW-1:0] tmo_cnt;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    checksum;
`endif

    logic xfer;
    logic active;
    logic tmo_hit;

    assign xfer    = bus.in_valid && bus.in_ready;
    assign tmo_hit = (TIMEOUT_CYC != 0) && (tmo_cnt == TMO_LAST);

    always_comb begin
        active = (state == S_LEN) || (state == S_HI) || (state == S_LO);
`ifdef LOADER_CHECKSUM_EN
        active = active || (state == S_CHK);
`endif
    end

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // branch below sees the values from before this clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            bus.in_ready <= 1'b0;
            bus.im_we    <= 1'b0;
            bus.im_addr  <= START;
            bus.im_wdata <= '0;
            cpu_hold     <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
            opcode       <= '0;
            remaining    <= '0;
            tmo_cnt      <= '0;
`ifdef LOADER_CHECKSUM_EN
            checksum     <= '0;
`endif
        end else begin
            bus.im_we <= 1'b0;
            // Address advances in the cycle the write strobe is visible.
            if (bus.im_we) bus.im_addr <= bus.im_addr + 1'b1;
            tmo_cnt <= (active && !xfer) ? tmo_cnt + 1'b1 : '0;

            case (state)
                S_IDLE: begin
                    bus.in_ready <= 1'b1;
                    if (xfer && bus.in_data == SYNC) begin
                        state        <= S_LEN;
                        cpu_hold     <= 1'b1;
                        done         <= 1'b0;
                        err          <= 1'b0;
                        words_loaded <= '0;
                        bus.im_addr  <= START;
                    end
                end

                S_LEN: begin
                    if (xfer) begin
                        remaining <= bus.in_data;
`ifdef LOADER_CHECKSUM_EN
                        checksum  <= bus.in_data;
`endif
                        if (int'(bus.in_data) > CAPACITY) begin
                            state        <= S_ERR;
                            bus.in_ready <= 1'b0;
                        end else if (bus.in_data == 8'd0) begin
                            state        <= S_TAIL;
                            bus.in_ready <= (S_TAIL != S_DONE);
                        end else begin
                            state <= S_HI;
                        end
                    end else if (tmo_hit) begin
                        state        <= S_ERR;
                        bus.in_ready <= 1'b0;
                    end
                end

                S_HI: begin
                    if (xfer) begin
                        if (bus.in_data[7]) begin
                            state        <= S_ERR;
                            bus.in_ready <= 1'b0;
                        end else begin
                            opcode   <= bus.in_data[6:0];
`ifdef LOADER_CHECKSUM_EN
                            checksum <= checksum + bus.in_data;
`endif
                            state    <= S_LO;
                        end
                    end else if (tmo_hit) begin
                        state        <= S_ERR;
                        bus.in_ready <= 1'b0;
                    end
                end

                S_LO: begin
                    if (xfer) begin
                        bus.im_we    <= 1'b1;
                        bus.im_wdata <= {opcode, bus.in_data};
                        words_loaded <= words_loaded + 8'd1;
                        remaining    <= remaining - 8'd1;
`ifdef LOADER_CHECKSUM_EN
                        checksum     <= checksum + bus.in_data;
`endif
                        if (remaining == 8'd1) begin
                            state        <= S_TAIL;
                            bus.in_ready <= (S_TAIL != S_DONE);
                        end else begin
                            state <= S_HI;
                        end
                    end else if (tmo_hit) begin
                        state        <= S_ERR;
                        bus.in_ready <= 1'b0;
                    end
                end

`ifdef LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (xfer) begin
                        state        <= (bus.in_data == checksum) ? S_DONE : S_ERR;
                        bus.in_ready <= 1'b0;
                    end else if (tmo_hit) begin
                        state        <= S_ERR;
                        bus.in_ready <= 1'b0;
                    end
                end
`endif

                S_DONE: begin
                    done         <= 1'b1;
                    cpu_hold     <= 1'b0;
                    bus.in_ready <= 1'b1;
                    state        <= S_IDLE;
                end

                // cpu_hold deliberately stays set: only a good frame releases the CPU.
                S_ERR: begin
                    err          <= 1'b1;
                    bus.in_ready <= 1'b1;
                    state        <= S_IDLE;
                end

                default: begin
                    state        <= S_IDLE;
                    bus.in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (START_ADDR=0, TIMEOUT_CYC=4); adapts its frames
// to whether LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

    localparam int ADDR_W = 8;

    typedef logic [7:0] byte_q_t[$];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cpu_hold;
    logic       done;
    logic       err;
    logic [7:0] words_loaded;

    int passed = 0;
    int total  = 0;

    logic [ADDR_W-1:0] wa[$];
    logic [14:0]       wd[$];

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(
        .ADDR_W     (ADDR_W),
        .START_ADDR (0),
        .TIMEOUT_CYC(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .cpu_hold    (cpu_hold),
        .done        (done),
        .err         (err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // Write log sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst_n && bus.im_we) begin
            wa.push_back(bus.im_addr);
            wd.push_back(bus.im_wdata);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 20) begin
            total++;
            $display("FAIL send_stall: byte %02h not accepted, in_ready=%0b after 20 cycles", b, bus.in_ready);
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input byte_q_t f);
        foreach (f[i]) send_byte(f[i]);
        bus.in_valid = 1'b0;
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
    endtask

    task automatic test_reset();
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        idle(2);
        total++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %0b want 0", bus.in_ready); else passed++;
        total++; if (bus.im_we !== 1'b0) $display("FAIL reset_im_we: got %0b want 0", bus.im_we); else passed++;
        total++; if (bus.im_addr !== 8'h00) $display("FAIL reset_im_addr: got %h want 00", bus.im_addr); else passed++;
        total++; if (bus.im_wdata !== 15'h0000) $display("FAIL reset_im_wdata: got %h want 0000", bus.im_wdata); else passed++;
        total++; if (cpu_hold !== 1'b0) $display("FAIL reset_cpu_hold: got %0b want 0", cpu_hold); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done: got %0b want 0", done); else passed++;
        total++; if (err !== 1'b0) $display("FAIL reset_err: got %0b want 0", err); else passed++;
        total++; if (words_loaded !== 8'd0) $display("FAIL reset_words: got %0d want 0", words_loaded); else passed++;
        rst_n = 1'b1;
        idle(2);
        total++; if (bus.in_ready !== 1'b1) $display("FAIL release_in_ready: got %0b want 1", bus.in_ready); else passed++;
    endtask

    task automatic test_good_frame();
        byte_q_t tail;
        clear_log();
        send_byte(8'hA5);
        total++; if (cpu_hold !== 1'b1) $display("FAIL good_hold_mid: got %0b want 1", cpu_hold); else passed++;
        send_byte(8'h02);
        send_byte(8'h05);
        send_byte(8'h10);
        total++; if (bus.im_we !== 1'b1) $display("FAIL good_we_latency: got %0b want 1", bus.im_we); else passed++;
        total++; if (bus.im_wdata !== 15'h0510) $display("FAIL good_wdata_latency: got %h want 0510", bus.im_wdata); else passed++;
        tail = '{8'h7F, 8'hFF};
`ifdef LOADER_CHECKSUM_EN
        tail.push_back(8'h95);
`endif
        send_frame(tail);
        idle(4);
        total++; if (wd.size() !== 2) $display("FAIL good_writes: got %0d want 2", wd.size()); else passed++;
        if (wd.size() == 2) begin
            total++; if (wa[0] !== 8'd0 || wd[0] !== 15'h0510) $display("FAIL good_word0: got %h@%h want 0510@00", wd[0], wa[0]); else passed++;
            total++; if (wa[1] !== 8'd1 || wd[1] !== 15'h7FFF) $display("FAIL good_word1: got %h@%h want 7fff@01", wd[1], wa[1]); else passed++;
        end
        total++; if (done !== 1'b1) $display("FAIL good_done: got %0b want 1", done); else passed++;
        total++; if (err !== 1'b0) $display("FAIL good_err: got %0b want 0", err); else passed++;
        total++; if (cpu_hold !== 1'b0) $display("FAIL good_hold: got %0b want 0", cpu_hold); else passed++;
        total++; if (words_loaded !== 8'd2) $display("FAIL good_words: got %0d want 2", words_loaded); else passed++;
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_bad_checksum();
        clear_log();
        send_frame('{8'hA5, 8'h01, 8'h03, 8'h04, 8'h00});
        idle(4);
        total++; if (wd.size() !== 1) $display("FAIL badchk_writes: got %0d want 1", wd.size()); else passed++;
        if (wd.size() == 1) begin
            total++; if (wa[0] !== 8'd0 || wd[0] !== 15'h0304) $display("FAIL badchk_word: got %h@%h want 0304@00", wd[0], wa[0]); else passed++;
        end
        total++; if (err !== 1'b1) $display("FAIL badchk_err: got %0b want 1", err); else passed++;
        total++; if (done !== 1'b0) $display("FAIL badchk_done: got %0b want 0", done); else passed++;
        total++; if (cpu_hold !== 1'b1) $display("FAIL badchk_hold: got %0b want 1", cpu_hold); else passed++;
    endtask
`endif

    task automatic test_single_word();
        byte_q_t f;
        clear_log();
        f = '{8'hA5, 8'h01, 8'h01, 8'h02};
`ifdef LOADER_CHECKSUM_EN
        f.push_back(8'h04);
`endif
        send_frame(f);
        idle(4);
        total++; if (wd.size() !== 1) $display("FAIL single_writes: got %0d want 1", wd.size()); else passed++;
        if (wd.size() == 1) begin
            total++; if (wa[0] !== 8'd0 || wd[0] !== 15'h0102) $display("FAIL single_word: got %h@%h want 0102@00", wd[0], wa[0]); else passed++;
        end
        total++; if (done !== 1'b1) $display("FAIL single_done: got %0b want 1", done); else passed++;
        total++; if (cpu_hold !== 1'b0) $display("FAIL single_hold: got %0b want 0", cpu_hold); else passed++;
    endtask

    task automatic test_bad_opcode();
        byte_q_t f;
        clear_log();
        send_frame('{8'hA5, 8'h01, 8'h80, 8'h11, 8'h22});
        idle(3);
        total++; if (wd.size() !== 0) $display("FAIL badop_writes: got %0d want 0", wd.size()); else passed++;
        total++; if (err !== 1'b1) $display("FAIL badop_err: got %0b want 1", err); else passed++;
        total++; if (done !== 1'b0) $display("FAIL badop_done: got %0b want 0", done); else passed++;
        total++; if (cpu_hold !== 1'b1) $display("FAIL badop_hold: got %0b want 1", cpu_hold); else passed++;
        // Junk must have been dropped: a clean frame now loads from address 0.
        f = '{8'hA5, 8'h01, 8'h12, 8'h34};
`ifdef LOADER_CHECKSUM_EN
        f.push_back(8'h47);
`endif
        send_frame(f);
        idle(4);
        total++; if (wd.size() !== 1) $display("FAIL recover_writes: got %0d want 1", wd.size()); else passed++;
        if (wd.size() == 1) begin
            total++; if (wa[0] !== 8'd0 || wd[0] !== 15'h1234) $display("FAIL recover_word: got %h@%h want 1234@00", wd[0], wa[0]); else passed++;
        end
        total++; if (cpu_hold !== 1'b0 || done !== 1'b1 || err !== 1'b0) $display("FAIL recover_status: got hold=%0b done=%0b err=%0b want 0 1 0", cpu_hold, done, err); else passed++;
    endtask

    task automatic test_timeout();
        byte_q_t f;
        clear_log();
        send_frame('{8'hA5, 8'h02, 8'h05});
        idle(3);
        total++; if (bus.in_ready !== 1'b1) $display("FAIL tmo_early: in_ready got %0b want 1 after 3 idle cycles", bus.in_ready); else passed++;
        idle(1);
        total++; if (bus.in_ready !== 1'b0) $display("FAIL tmo_fire: in_ready got %0b want 0 after 4 idle cycles", bus.in_ready); else passed++;
        idle(2);
        total++; if (err !== 1'b1) $display("FAIL tmo_err: got %0b want 1", err); else passed++;
        total++; if (wd.size() !== 0) $display("FAIL tmo_writes: got %0d want 0", wd.size()); else passed++;
        total++; if (cpu_hold !== 1'b1) $display("FAIL tmo_hold: got %0b want 1", cpu_hold); else passed++;

        // Same frame, next byte lands in the 4th idle cycle: it must win.
        clear_log();
        send_frame('{8'hA5, 8'h02, 8'h05});
        idle(3);
        f = '{8'h10, 8'h7F, 8'hFF};
`ifdef LOADER_CHECKSUM_EN
        f.push_back(8'h95);
`endif
        send_frame(f);
        idle(4);
        total++; if (err !== 1'b0) $display("FAIL tmo_edge_err: got %0b want 0", err); else passed++;
        total++; if (done !== 1'b1) $display("FAIL tmo_edge_done: got %0b want 1", done); else passed++;
        total++; if (wd.size() !== 2) $display("FAIL tmo_edge_writes: got %0d want 2", wd.size()); else passed++;
    endtask

    task automatic test_zero_len();
        byte_q_t f;
        clear_log();
        f = '{8'hA5, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        f.push_back(8'h00);
`endif
        send_frame(f);
        idle(4);
        total++; if (done !== 1'b1) $display("FAIL zero_done: got %0b want 1", done); else passed++;
        total++; if (wd.size() !== 0) $display("FAIL zero_writes: got %0d want 0", wd.size()); else passed++;
        total++; if (words_loaded !== 8'd0) $display("FAIL zero_words: got %0d want 0", words_loaded); else passed++;
        total++; if (cpu_hold !== 1'b0) $display("FAIL zero_hold: got %0b want 0", cpu_hold); else passed++;
    endtask

    task automatic test_reset_mid_frame();
        byte_q_t f;
        clear_log();
        send_frame('{8'hA5, 8'h02, 8'h05, 8'h10});
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (bus.in_ready !== 1'b0) $display("FAIL midrst_in_ready: got %0b want 0", bus.in_ready); else passed++;
        total++; if (bus.im_we !== 1'b0) $display("FAIL midrst_im_we: got %0b want 0", bus.im_we); else passed++;
        total++; if (bus.im_addr !== 8'h00 || bus.im_wdata !== 15'h0000) $display("FAIL midrst_bus: got addr=%h wdata=%h want 00 0000", bus.im_addr, bus.im_wdata); else passed++;
        total++; if (cpu_hold !== 1'b0 || done !== 1'b0 || err !== 1'b0) $display("FAIL midrst_status: got hold=%0b done=%0b err=%0b want 0 0 0", cpu_hold, done, err); else passed++;
        total++; if (words_loaded !== 8'd0) $display("FAIL midrst_words: got %0d want 0", words_loaded); else passed++;
        idle(2);
        rst_n = 1'b1;
        idle(2);
        clear_log();
        f = '{8'hA5, 8'h01, 8'h12, 8'h34};
`ifdef LOADER_CHECKSUM_EN
        f.push_back(8'h47);
`endif
        send_frame(f);
        idle(4);
        total++; if (wd.size() !== 1) $display("FAIL postrst_writes: got %0d want 1", wd.size()); else passed++;
        if (wd.size() == 1) begin
            total++; if (wa[0] !== 8'd0 || wd[0] !== 15'h1234) $display("FAIL postrst_word: got %h@%h want 1234@00", wd[0], wa[0]); else passed++;
        end
        total++; if (done !== 1'b1) $display("FAIL postrst_done: got %0b want 1", done); else passed++;
    endtask

    initial begin
        test_reset();
        test_good_frame();
`ifdef LOADER_CHECKSUM_EN
        test_bad_checksum();
`endif
        test_single_word();
        test_bad_opcode();
        test_timeout();
        test_zero_len();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
